// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key schedule.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam logic [7:0]  RCON_INIT     = 8'h01;

  typedef enum logic {StIdle, StRun} ks_state_e;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One combinational AES-128 key expansion step: previous round key -> next round key.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot_w3, sub_w3, t;
  aes_word_t n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  // RotWord: left rotate by one byte.
  assign rot_w3 = {w3[23:0], w3[31:24]};

  sub_bytes #(
    .NumBytes(4)
  ) u_sub_word (
    .data_i(rot_w3),
    .data_o(sub_w3)
  );

  // Word chaining for the next round key.
  always_comb begin
    t     = sub_w3 ^ {rcon_i, 24'h0};
    n0    = w0 ^ t;
    n1    = w1 ^ n0;
    n2    = w2 ^ n1;
    n3    = w3 ^ n2;
    key_o = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/sub_bytes.sv
// Byte-parallel AES forward S-box.
module sub_bytes #(
  parameter int unsigned NumBytes = 16
) (
  input  logic [8*NumBytes-1:0] data_i,
  output logic [8*NumBytes-1:0] data_o
);

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar i = 0; i < NumBytes; i++) begin : gen_byte
    assign data_o[8*i +: 8] = Sbox[data_i[8*i +: 8]];
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key expander streaming round keys 0..10 over a valid/ready handshake.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int unsigned num_rounds_p = AES128_ROUNDS,
  parameter int unsigned idx_width_p  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [127:0]           key_i,
  input  logic                   key_v_i,
  output logic                   key_ready_o,
  output logic [127:0]           round_key_o,
  output logic [idx_width_p-1:0] round_idx_o,
  output logic                   round_key_v_o,
  input  logic                   round_key_ready_i,
  output logic                   last_o
);

  if (num_rounds_p != AES128_ROUNDS) begin : gen_bad_rounds
    $error("num_rounds_p must be %0d (AES-128 only)", AES128_ROUNDS);
  end
  if ((64'd1 << idx_width_p) <= 64'(num_rounds_p)) begin : gen_bad_idx_width
    $error("idx_width_p too narrow for num_rounds_p");
  end

  localparam logic [idx_width_p-1:0] LastIdx = idx_width_p'(num_rounds_p);

  ks_state_e              state_q, state_d;
  logic [127:0]           cur_key_q, cur_key_d;
  logic [idx_width_p-1:0] round_idx_q, round_idx_d;
  logic [7:0]             rcon_q, rcon_d;
  // Holds key_ready_o low until the first edge after reset release.
  logic                   active_q;
  logic [127:0]           next_key;
  logic                   key_take, rk_xfer, is_last;

  aes_key_expand_step u_expand (
    .key_i (cur_key_q),
    .rcon_i(rcon_q),
    .key_o (next_key)
  );

  assign key_take = (state_q == StIdle) && active_q && key_v_i;
  assign rk_xfer  = (state_q == StRun) && round_key_ready_i;
  assign is_last  = (round_idx_q == LastIdx);

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (key_take) state_d = StRun;
      StRun:  if (rk_xfer && is_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; all data outputs come straight from registers.
  always_comb begin
    key_ready_o   = (state_q == StIdle) && active_q;
    round_key_v_o = (state_q == StRun);
    last_o        = (state_q == StRun) && is_last;
    round_key_o   = cur_key_q;
    round_idx_o   = round_idx_q;
  end

  // Datapath next-state: load on key accept, advance on non-final transfer.
  always_comb begin
    cur_key_d   = cur_key_q;
    round_idx_d = round_idx_q;
    rcon_d      = rcon_q;
    if (key_take) begin
      cur_key_d   = key_i;
      round_idx_d = '0;
      rcon_d      = RCON_INIT;
    end else if (rk_xfer && !is_last) begin
      cur_key_d   = next_key;
      round_idx_d = round_idx_q + idx_width_p'(1);
      rcon_d      = xtime(rcon_q);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cur_key_q   <= '0;
      round_idx_q <= '0;
      rcon_q      <= RCON_INIT;
      active_q    <= 1'b0;
    end else begin
      cur_key_q   <= cur_key_d;
      round_idx_q <= round_idx_d;
      rcon_q      <= rcon_d;
      active_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq using FIPS-197 round-key vectors.
module tb_aes_key_schedule_seq;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic [127:0] key_i;
  logic         key_v_i;
  logic         key_ready_o;
  logic [127:0] round_key_o;
  logic [3:0]   round_idx_o;
  logic         round_key_v_o;
  logic         round_key_ready_i;
  logic         last_o;

  aes_key_schedule_seq dut (
    .clk_i            (clk_i),
    .reset_ni         (rst_n),
    .key_i            (key_i),
    .key_v_i          (key_v_i),
    .key_ready_o      (key_ready_o),
    .round_key_o      (round_key_o),
    .round_idx_o      (round_idx_o),
    .round_key_v_o    (round_key_v_o),
    .round_key_ready_i(round_key_ready_i),
    .last_o           (last_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [127:0] KeyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyB = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    int           key_sel;
    int           idx;
    logic [127:0] exp_rk;
    logic         exp_last;
  } vec_t;

  vec_t vecs [14];

  int n_err = 0;
  int n_checks = 0;

  logic [127:0] got_rk [11];
  logic         got_last [11];
  int           got_n, got_valid;
  logic         bad_stable, bad_kr, bad_order, bad_last, timed_out;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_table(input int sel, input string tag);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].key_sel == sel) begin
        check($sformatf("%s rk%0d", tag, vecs[i].idx), got_rk[vecs[i].idx], vecs[i].exp_rk);
        check($sformatf("%s last%0d", tag, vecs[i].idx), 128'(got_last[vecs[i].idx]),
              128'(vecs[i].exp_last));
      end
    end
  endtask

  // Waits (bounded) for key_ready_o, presents the key and lets one edge accept it.
  task automatic accept_key(input logic [127:0] k, input bit hold);
    int n;
    key_i   = k;
    key_v_i = 1'b1;
    n = 0;
    while (!key_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!key_ready_o) check("key_ready timeout", 128'(key_ready_o), 128'd1);
    @(posedge clk_i); #1;
    if (!hold) key_v_i = 1'b0;
  endtask

  // Consumes one round-key stream, recording keys and handshake invariants.
  task automatic drain(input bit rand_ready);
    bit           done, held_v, rdy;
    logic [127:0] held_rk;
    logic [3:0]   held_idx;
    done = 0; held_v = 0; held_rk = '0; held_idx = '0;
    got_n = 0; got_valid = 0;
    bad_stable = 0; bad_kr = 0; bad_order = 0; bad_last = 0;
    for (int i = 0; i < 11; i++) begin
      got_rk[i]   = 'x;
      got_last[i] = 1'bx;
    end
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      round_key_ready_i = rdy;
      if (round_key_v_o) begin
        got_valid++;
        if (key_ready_o) bad_kr = 1;
        if (last_o !== (round_idx_o == 4'd10)) bad_last = 1;
        if (held_v && (round_key_o !== held_rk || round_idx_o !== held_idx)) bad_stable = 1;
        if (rdy) begin
          if (got_n <= 10) begin
            got_rk[got_n]   = round_key_o;
            got_last[got_n] = last_o;
            if (round_idx_o != 4'(got_n)) bad_order = 1;
          end else begin
            bad_order = 1;
          end
          got_n++;
          held_v = 0;
          if (last_o) done = 1;
        end else begin
          held_v   = 1;
          held_rk  = round_key_o;
          held_idx = round_idx_o;
        end
      end else begin
        bad_order = 1;
      end
      @(posedge clk_i); #1;
    end
    round_key_ready_i = 1'b0;
    timed_out = !done;
    if (timed_out) check("stream timeout", 128'(done), 128'd1);
  endtask

  initial begin
    vecs[0]  = '{0, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
    vecs[1]  = '{0, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
    vecs[2]  = '{0, 2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
    vecs[3]  = '{0, 3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0};
    vecs[4]  = '{0, 4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b0};
    vecs[5]  = '{0, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0};
    vecs[6]  = '{0, 6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0};
    vecs[7]  = '{0, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0};
    vecs[8]  = '{0, 8,  128'head27321b58dbad2312bf5607f8d292f, 1'b0};
    vecs[9]  = '{0, 9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
    vecs[10] = '{0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
    vecs[11] = '{1, 0,  128'h000102030405060708090a0b0c0d0e0f, 1'b0};
    vecs[12] = '{1, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 1'b0};
    vecs[13] = '{1, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};

    rst_n = 1'b0;
    key_i = '0;
    key_v_i = 1'b0;
    round_key_ready_i = 1'b0;

    // Reset state.
    #1;
    check("rst key_ready", 128'(key_ready_o), 128'd0);
    check("rst rk_v", 128'(round_key_v_o), 128'd0);
    check("rst last", 128'(last_o), 128'd0);
    check("rst rk", round_key_o, 128'd0);
    check("rst idx", 128'(round_idx_o), 128'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i); #1;
    check("post-rst key_ready", 128'(key_ready_o), 128'd1);

    // Idle: no key offered.
    begin
      bit bad_idle = 0;
      for (int i = 0; i < 20; i++) begin
        if (round_key_v_o !== 1'b0 || key_ready_o !== 1'b1) bad_idle = 1;
        @(posedge clk_i); #1;
      end
      check("idle hold", 128'(bad_idle), 128'd0);
    end

    // Key A with ready held high.
    accept_key(KeyA, 1'b0);
    check("A first-cycle valid", 128'(round_key_v_o), 128'd1);
    drain(1'b0);
    check("A valid cycles", 128'(got_valid), 128'd11);
    check("A transfers", 128'(got_n), 128'd11);
    check("A order", 128'(bad_order), 128'd0);
    check_table(0, "A");
    check("A ready after last", 128'(key_ready_o), 128'd1);

    // Key B with ready held high.
    accept_key(KeyB, 1'b0);
    drain(1'b0);
    check("B transfers", 128'(got_n), 128'd11);
    check_table(1, "B");

    // Key A under random backpressure.
    accept_key(KeyA, 1'b0);
    drain(1'b1);
    check("BP transfers", 128'(got_n), 128'd11);
    check("BP stable", 128'(bad_stable), 128'd0);
    check("BP key_ready low", 128'(bad_kr), 128'd0);
    check("BP last", 128'(bad_last), 128'd0);
    check("BP order", 128'(bad_order), 128'd0);
    check_table(0, "BP");

    // Back-to-back with key_v_i held high: A then B.
    accept_key(KeyA, 1'b1);
    key_i = KeyB;
    drain(1'b0);
    check("B2B A transfers", 128'(got_n), 128'd11);
    check("B2B A order", 128'(bad_order), 128'd0);
    check_table(0, "B2B-A");
    check("B2B gap ready", 128'(key_ready_o), 128'd1);
    check("B2B gap rk_v", 128'(round_key_v_o), 128'd0);
    @(posedge clk_i); #1;
    key_v_i = 1'b0;
    check("B2B B accepted", 128'(round_key_v_o), 128'd1);
    check("B2B B idx0", 128'(round_idx_o), 128'd0);
    drain(1'b0);
    check("B2B B transfers", 128'(got_n), 128'd11);
    check_table(1, "B2B-B");

    // Asynchronous reset in the middle of a stream.
    accept_key(KeyA, 1'b0);
    round_key_ready_i = 1'b1;
    for (int i = 0; i < 20 && round_idx_o != 4'd5; i++) begin
      @(posedge clk_i); #1;
    end
    check("mid idx5", 128'(round_idx_o), 128'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async key_ready", 128'(key_ready_o), 128'd0);
    check("async rk_v", 128'(round_key_v_o), 128'd0);
    check("async last", 128'(last_o), 128'd0);
    check("async rk", round_key_o, 128'd0);
    check("async idx", 128'(round_idx_o), 128'd0);
    round_key_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i); #1;
    check("re-rst key_ready", 128'(key_ready_o), 128'd1);
    accept_key(KeyB, 1'b0);
    drain(1'b0);
    check("post-rst transfers", 128'(got_n), 128'd11);
    check_table(1, "RST-B");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
